// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply controller for a^e mod n. Sequences one external
// pre-transform unit and one Montgomery multiplier; supports abort with drain of in-flight work.
module rsa_modexp_ctrl #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_e,
  input  logic [WIDTH-1:0] i_n,
  input  logic [CW-1:0]    i_ebits,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_trans_start,
  output logic [WIDTH-1:0] o_trans_a,
  input  logic             i_trans_done,
  input  logic [WIDTH-1:0] i_trans_result,
  output logic             o_mul_start,
  output logic [WIDTH-1:0] o_mul_a,
  output logic [WIDTH-1:0] o_mul_b,
  output logic [WIDTH-1:0] o_n,
  input  logic             i_mul_done,
  input  logic [WIDTH-1:0] i_mul_result
);

  typedef enum logic [3:0] {
    StIdle, StTrans, StWaitT, StMul, StWaitM, StSqr, StWaitS, StFin, StDrain
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] e_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] base_q;
  logic [CW-1:0]    idx_q;
  logic [CW-1:0]    last_q;
  logic             drain_mul_q;
  logic [CW-1:0]    idx_inc;

  assign idx_inc = idx_q + CW'(1);

  // e_q shifts right as bits are consumed, so e_q[0] is always the bit at idx_q.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q       <= StIdle;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_result      <= '0;
      o_trans_start <= 1'b0;
      o_trans_a     <= '0;
      o_mul_start   <= 1'b0;
      o_mul_a       <= '0;
      o_mul_b       <= '0;
      o_n           <= '0;
      e_q           <= '0;
      res_q         <= '0;
      base_q        <= '0;
      idx_q         <= '0;
      last_q        <= '0;
      drain_mul_q   <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      o_trans_start <= 1'b0;
      o_mul_start   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start && !i_abort) begin
            o_trans_a <= i_a;
            o_n       <= i_n;
            e_q       <= i_e;
            last_q    <= i_ebits - CW'(1);
            res_q     <= WIDTH'(1);
            idx_q     <= '0;
            o_busy    <= 1'b1;
            state_q   <= (i_ebits == '0) ? StFin : StTrans;
          end
        end
        StTrans: begin
          if (i_abort) begin
            o_busy  <= 1'b0;
            state_q <= StIdle;
          end else begin
            o_trans_start <= 1'b1;
            state_q       <= StWaitT;
          end
        end
        StWaitT: begin
          if (i_abort) begin
            drain_mul_q <= 1'b0;
            o_busy      <= !i_trans_done;
            state_q     <= i_trans_done ? StIdle : StDrain;
          end else if (i_trans_done) begin
            base_q <= i_trans_result;
            if (e_q[0])                state_q <= StMul;
            else if (idx_q == last_q)  state_q <= StFin;
            else                       state_q <= StSqr;
          end
        end
        StMul, StSqr: begin
          if (i_abort) begin
            o_busy  <= 1'b0;
            state_q <= StIdle;
          end else begin
            o_mul_a     <= (state_q == StMul) ? res_q : base_q;
            o_mul_b     <= base_q;
            o_mul_start <= 1'b1;
            state_q     <= (state_q == StMul) ? StWaitM : StWaitS;
          end
        end
        StWaitM: begin
          if (i_abort) begin
            drain_mul_q <= 1'b1;
            o_busy      <= !i_mul_done;
            state_q     <= i_mul_done ? StIdle : StDrain;
          end else if (i_mul_done) begin
            res_q   <= i_mul_result;
            state_q <= (idx_q == last_q) ? StFin : StSqr;
          end
        end
        StWaitS: begin
          if (i_abort) begin
            drain_mul_q <= 1'b1;
            o_busy      <= !i_mul_done;
            state_q     <= i_mul_done ? StIdle : StDrain;
          end else if (i_mul_done) begin
            base_q <= i_mul_result;
            idx_q  <= idx_inc;
            e_q    <= e_q >> 1;
            // Squaring after the final bit is never issued.
            if (e_q[1])                  state_q <= StMul;
            else if (idx_inc == last_q)  state_q <= StFin;
            else                         state_q <= StSqr;
          end
        end
        StFin: begin
          if (!i_abort) begin
            o_result <= res_q;
            o_done   <= 1'b1;
          end
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
        StDrain: begin
          if ((drain_mul_q && i_mul_done) || (!drain_mul_q && i_trans_done)) begin
            o_busy  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          o_busy  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl at WIDTH=16 with random-latency behavioural trans/mul units.
module tb_rsa_modexp_ctrl;
  localparam int unsigned W  = 16;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [W-1:0]  a, e, n;
  logic [CW-1:0] ebits;
  logic          busy, done;
  logic [W-1:0]  result;
  logic          trans_start, trans_done;
  logic [W-1:0]  trans_a, trans_result;
  logic          mul_start, mul_done;
  logic [W-1:0]  mul_a, mul_b, n_out, mul_result;

  logic          t_done = 1'b0;
  logic [W-1:0]  t_res = '0;
  logic          m_done = 1'b0;
  logic [W-1:0]  m_res = '0;
  logic          man_done = 1'b0;
  bit            auto_mul = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int mul_cnt = 0, trans_cnt = 0, done_cnt = 0;

  assign trans_done   = t_done;
  assign trans_result = t_res;
  assign mul_done     = m_done | man_done;
  assign mul_result   = man_done ? 16'h0bad : m_res;

  always #5 clk = ~clk;

  rsa_modexp_ctrl #(.WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
    .i_a(a), .i_e(e), .i_n(n), .i_ebits(ebits),
    .o_busy(busy), .o_done(done), .o_result(result),
    .o_trans_start(trans_start), .o_trans_a(trans_a),
    .i_trans_done(trans_done), .i_trans_result(trans_result),
    .o_mul_start(mul_start), .o_mul_a(mul_a), .o_mul_b(mul_b), .o_n(n_out),
    .i_mul_done(mul_done), .i_mul_result(mul_result)
  );

  // Montgomery product a*b*2^-16 mod n, bit-serial.
  function automatic logic [W-1:0] mont(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic [W-1:0] m);
    longint unsigned t = 0;
    for (int i = 0; i < W; i++) begin
      if (x[i]) t += longint'(y);
      if ((t & 1) != 0) t += longint'(m);
      t = t >> 1;
    end
    if (t >= longint'(m)) t -= longint'(m);
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] ref_pow(input int unsigned x, input int unsigned ex,
                                           input int unsigned m, input int unsigned eb);
    longint unsigned r = 1;
    longint unsigned b = x % m;
    for (int i = 0; i < int'(eb); i++) begin
      if (((ex >> i) & 1) != 0) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic int ref_muls(input int unsigned ex, input int unsigned eb);
    int c = 0;
    for (int i = 0; i < int'(eb); i++) if (((ex >> i) & 1) != 0) c++;
    return (eb == 0) ? 0 : c + int'(eb) - 1;
  endfunction

  always begin
    @(negedge clk);
    if (trans_start) begin
      automatic logic [W-1:0] ta = trans_a;
      automatic logic [W-1:0] tn = n_out;
      automatic int lat = $urandom_range(1, 20);
      repeat (lat) @(negedge clk);
      t_res  = (tn == 0) ? '0 : W'((longint'(ta) << W) % longint'(tn));
      t_done = 1'b1;
      @(negedge clk);
      t_done = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    if (mul_start && auto_mul) begin
      automatic logic [W-1:0] ma = mul_a;
      automatic logic [W-1:0] mb = mul_b;
      automatic logic [W-1:0] mn = n_out;
      automatic int lat = $urandom_range(1, 20);
      repeat (lat) @(negedge clk);
      m_res  = mont(ma, mb, mn);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mul_start)   mul_cnt++;
    if (trans_start) trans_cnt++;
    if (done)        done_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xe, input logic [W-1:0] xn,
                        input int unsigned eb, input bit poke, output logic [W-1:0] res,
                        output int muls, output int trs, output int dns);
    int m0 = mul_cnt;
    int t0 = trans_cnt;
    int d0 = done_cnt;
    @(negedge clk);
    a = xa; e = xe; n = xn; ebits = CW'(eb); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      a = 16'h1234; e = 16'h0003; n = 16'h0011; ebits = CW'(2); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < 3000 && done_cnt == d0; c++) @(negedge clk);
    repeat (4) @(negedge clk);
    res  = result;
    muls = mul_cnt - m0;
    trs  = trans_cnt - t0;
    dns  = done_cnt - d0;
  endtask

  typedef struct {
    logic [W-1:0] a, e, n;
    int unsigned  eb;
    logic [W-1:0] exp_res;
    int           exp_muls, exp_trans;
  } vec_t;

  initial begin
    vec_t vecs[7];
    logic [W-1:0] res;
    int muls, trs, dns, d0, bcnt;
    bit found;

    vecs[0] = '{16'd5,  16'd3,      16'd23,     2,  16'd10,   3,  1};
    vecs[1] = '{16'd7,  16'hffff,   16'hfff1,   16, 16'd6839, 31, 1};
    vecs[2] = '{16'd2,  16'h00ff,   16'd101,    4,  16'd44,   7,  1};
    vecs[3] = '{16'd7,  16'h00ff,   16'hfff1,   0,  16'd1,    0,  0};
    vecs[4] = '{16'd3,  16'd5,      16'd97,     4,  16'd49,   5,  1};
    vecs[5] = '{16'd9,  16'd0,      16'd11,     1,  16'd1,    0,  1};
    vecs[6] = '{16'd9,  16'd1,      16'd11,     1,  16'd9,    1,  1};

    rst = 1'b0; start = 1'b0; abort = 1'b0; a = '0; e = '0; n = '0; ebits = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, trans_start, mul_start}, 0);
    check("reset_data", {result, trans_a, mul_a, mul_b}, 0);
    check("reset_n", n_out, 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].e, vecs[i].n, vecs[i].eb, vecs[i].eb >= 8, res, muls, trs, dns);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_muls", i), muls, vecs[i].exp_muls);
      check($sformatf("vec%0d_trans", i), trs, vecs[i].exp_trans);
      check($sformatf("vec%0d_dones", i), dns, 1);
    end

    for (int k = 0; k < 20; k++) begin
      automatic int unsigned rn = $urandom_range(3, 65535) | 1;
      automatic int unsigned ra = $urandom % rn;
      automatic int unsigned re = $urandom_range(0, 65535);
      automatic int unsigned rb = $urandom_range(0, 16);
      run_op(W'(ra), W'(re), W'(rn), rb, 1'b0, res, muls, trs, dns);
      check($sformatf("rand%0d_result", k), res, ref_pow(ra, re, rn, rb));
      check($sformatf("rand%0d_muls", k), muls, ref_muls(re, rb));
      check($sformatf("rand%0d_dones", k), dns, 1);
    end

    // Known prior result before abort scenarios.
    run_op(16'd5, 16'd3, 16'd23, 2, 1'b0, res, muls, trs, dns);
    check("prior_result", res, 16'd10);

    // Start together with abort in idle: abort wins.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; a = 16'd7; e = 16'hffff; n = 16'hfff1; ebits = CW'(16);
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", busy, 0);

    // Abort while waiting on a multiply, done arrives 5 cycles later.
    auto_mul = 1'b0;
    d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      found = mul_start;
    end
    check("abort_mul_start_seen", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_busy_before_done", busy, 1);
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("drain_busy_after_done", busy, 0);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_result_held", result, 16'd10);
    auto_mul = 1'b1;
    run_op(16'd2, 16'h00ff, 16'd101, 4, 1'b0, res, muls, trs, dns);
    check("after_abort_result", res, 16'd44);

    // Asynchronous reset while a squaring is in flight.
    d0 = done_cnt;
    @(negedge clk);
    a = 16'd7; e = 16'hffff; n = 16'hfff1; ebits = CW'(16); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      found = mul_start && (mul_a == mul_b);
    end
    check("sqr_start_seen", found, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_ctrl", {busy, done, trans_start, mul_start}, 0);
    check("async_rst_data", {result, trans_a, mul_a, mul_b}, 0);
    check("async_rst_n", n_out, 0);
    @(negedge clk);
    rst = 1'b1;
    bcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    check("stray_done_busy", bcnt, 0);
    check("stray_done_no_done", done_cnt - d0, 0);
    check("stray_done_result", result, 0);
    run_op(16'd5, 16'd3, 16'd23, 2, 1'b0, res, muls, trs, dns);
    check("after_reset_result", res, 16'd10);
    check("after_reset_muls", muls, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
